ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch front end. Feeds the issue decoder one instruction at a time through the `ins_ready`/`ins`/`pc`/`predict_nxt_pc` interface, and honours the decoder's stall and redirect signals.
- Fetches 32-bit words from the memory controller through a request/ready handshake.
- Performs static branch prediction: backward branches are taken.
- Accepts misprediction redirects from the ROB.

Parameters:
RESET_PC, 32'h0, fetch address after reset
ICACHE_IDX_W, 4, log2 of icache line count (one word per line)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; when low, all state holds
ins_ready  output  1  `ins`/`pc`/`predict_nxt_pc` valid
ins  output  32  instruction word
pc  output  32  {fetch_pc[31:1], predicted_taken}
predict_nxt_pc  output  32  alternate-path address for recovery
dec_stall  input  1  decoder cannot accept presented instruction
dec_clear  input  1  one-cycle redirect pulse from decoder (JAL/JALR)
dec_new_addr  input  32  redirect target for dec_clear
rob_clear  input  1  one-cycle mispredict flush pulse
rob_new_addr  input  32  correct PC for rob_clear
mem_req  output  1  one-cycle fetch request pulse
mem_addr  output  32  word address of request
mem_ready  input  1  one-cycle response pulse
mem_data  input  32  response word

Behaviour:
- Reset (asynchronous, `rst_n_in` low):
  - fpc=RESET_PC; state=S_FETCH.
  - `ins_ready`, `ins`, `pc`, `predict_nxt_pc`, `mem_req`, `mem_addr` = 0.
  - All icache valid bits = 0; drop flag = 0.
- `rdy_in`=0: no state, register or output changes.
- Consume: a posedge with `ins_ready`=1 and `dec_stall`=0. While stalled, all outputs stay stable.
- States:
  - S_FETCH:
    - icache hit on fpc → register word, go to S_PRESENT (visible next cycle).
    - Miss → `mem_req`=1 for one cycle, `mem_addr`={fpc[31:2],2'b00}, go to S_WAIT.
  - S_WAIT: on `mem_ready`:
    - drop=0 → write icache line, register word, go to S_PRESENT.
    - drop=1 → clear drop, go to S_FETCH (word discarded, no cache write).
  - S_PRESENT: `ins_ready`=1. On consume, `ins_ready` drops next cycle. Next state by opcode (`ins[6:0]`):
    - JAL (1101111) / JALR (1100111) → S_JHOLD; fpc unchanged.
    - B-type (1100011): imm = sign-extended {ins[31],ins[7],ins[30:25],ins[11:8],0}.
      - imm[31]=1 → predicted taken: `pc[0]`=1, `predict_nxt_pc`=fpc+4, next fpc=fpc+imm.
      - Otherwise → `pc[0]`=0, `predict_nxt_pc`=fpc+imm, next fpc=fpc+4.
      - `pc` and `predict_nxt_pc` are computed when the word is registered; next fpc is applied at consume. Go to S_FETCH.
    - Other opcodes → fpc+4, S_FETCH; `pc[0]`=0, `predict_nxt_pc`=fpc+4.
  - S_JHOLD: no fetch; wait for `dec_clear` or `rob_clear`.
- Redirect (any state):
  - `rob_clear` has priority over `dec_clear`.
  - fpc ← new address with bit 0 forced to 0; `ins_ready` ← 0 same edge.
  - If in S_WAIT with no `mem_ready` that cycle → set drop, stay in S_WAIT. Otherwise → S_FETCH.
  - `rob_clear` together with `mem_ready` in S_WAIT: the response is discarded and not cached.
- Arithmetic is 32-bit wrapping; fpc+4 at 32'hFFFFFFFC wraps to 0.
- Icache:
  - Direct-mapped: index fpc[ICACHE_IDX_W+1:2], tag fpc[31:ICACHE_IDX_W+2].
  - Invalidated only at reset. Never written by stores.
- Only one memory request is outstanding at a time.

Optional Feature:
- Macro: IFETCH_ICACHE_EN.
- Defined: icache present, behaviour as above.
- Undefined: no icache storage; every S_FETCH misses and issues `mem_req`; hit path removed.

Test Plan:
- Reset at RESET_PC=0 with memory latency 3: `mem_req` pulses with `mem_addr`=0 → `ins_ready`=1 four cycles later; `pc`=0, `predict_nxt_pc`=4.
- ADDI at 0x0, then 0x4: consume at 0x0 → next `mem_addr`=0x4. Hold `dec_stall`=1 for 5 cycles → `ins`/`pc` unchanged throughout.
- BNE at 0x10 with imm=-8 (0xFE001CE3 form) → `pc`=0x11, `predict_nxt_pc`=0x14, next fetch 0x08. Repeat with imm=+8 → `pc`=0x10, `predict_nxt_pc`=0x18, next fetch 0x14.
- JAL at 0x20 consumed → no `mem_req` until `dec_clear` with `dec_new_addr`=0x100 → `mem_req` with `mem_addr`=0x100 next cycle.
- `rob_clear` to 0x200 while S_WAIT on 0x40 → the returned 0x40 word is discarded and `ins_ready` stays 0; then `mem_addr`=0x200; presented `pc`=0x200.
- Loop 0x0→0x4→0x8 (backward branch) run twice with IFETCH_ICACHE_EN: second pass issues no `mem_req`; `ins_ready` one cycle after each consume. Without the macro, `mem_req` is issued every pass.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: decoder-facing instruction channel, redirect inputs and memory port.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifetch_unit_if;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] predict_nxt_pc;
    logic        dec_stall;
    logic        dec_clear;
    logic [31:0] dec_new_addr;
    logic        rob_clear;
    logic [31:0] rob_new_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport master (
        output ins_ready, ins, pc, predict_nxt_pc, mem_req, mem_addr,
        input  dec_stall, dec_clear, dec_new_addr, rob_clear, rob_new_addr, mem_ready, mem_data
    );

    modport slave (
        input  ins_ready, ins, pc, predict_nxt_pc, mem_req, mem_addr,
        output dec_stall, dec_clear, dec_new_addr, rob_clear, rob_new_addr, mem_ready, mem_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end with static backward-taken branch prediction and redirects.
// Define IFETCH_ICACHE_EN to add a direct-mapped, one-word-per-line instruction cache.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ICACHE_IDX_W = 4
) (
    input logic           clk_in,
    input logic           rst_n_in,
    input logic           rdy_in,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {StFetch, StWait, StPresent, StJhold} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        drop_q, drop_d;
    logic        ins_ready_q, ins_ready_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pnpc_q, pnpc_d;
    logic [31:0] nfpc_q, nfpc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic        cache_hit;
    logic [31:0] cache_word;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        load;
    logic [31:0] word_in, br_imm, seq_pc, br_pc;
    logic        is_branch, is_jump_in, taken;

    function automatic logic is_jump(input logic [6:0] op);
        return (op == 7'b1101111) || (op == 7'b1100111);
    endfunction

    // Decode of the word being registered: the prediction is fixed at load time.
    always_comb begin
        word_in    = (state_q == StWait) ? bus.mem_data : cache_word;
        br_imm     = {{20{word_in[31]}}, word_in[7], word_in[30:25], word_in[11:8], 1'b0};
        seq_pc     = fpc_q + 32'd4;
        br_pc      = fpc_q + br_imm;
        is_branch  = (word_in[6:0] == 7'b1100011);
        is_jump_in = is_jump(word_in[6:0]);
        taken      = is_branch & br_imm[31];
    end

    assign redirect      = bus.rob_clear | bus.dec_clear;
    assign redirect_addr = bus.rob_clear ? bus.rob_new_addr : bus.dec_new_addr;

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_d      = drop_q;
        ins_ready_d = ins_ready_q;
        ins_d       = ins_q;
        pc_d        = pc_q;
        pnpc_d      = pnpc_q;
        nfpc_d      = nfpc_q;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        load        = 1'b0;
        if (redirect) begin
            fpc_d       = {redirect_addr[31:1], 1'b0};
            ins_ready_d = 1'b0;
            // An in-flight response must still be absorbed, so stay in StWait and discard it.
            if (state_q == StWait && !bus.mem_ready) begin
                drop_d  = 1'b1;
                state_d = StWait;
            end else begin
                drop_d  = 1'b0;
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (cache_hit) begin
                        load = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {fpc_q[31:2], 2'b00};
                        state_d    = StWait;
                    end
                end
                StWait: begin
                    if (bus.mem_ready) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = StFetch;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                StPresent: begin
                    if (!bus.dec_stall) begin
                        ins_ready_d = 1'b0;
                        fpc_d       = nfpc_q;
                        state_d     = is_jump(ins_q[6:0]) ? StJhold : StFetch;
                    end
                end
                StJhold: begin
                end
            endcase
            if (load) begin
                ins_ready_d = 1'b1;
                ins_d       = word_in;
                pc_d        = {fpc_q[31:1], taken};
                pnpc_d      = (is_branch && !taken) ? br_pc : seq_pc;
                nfpc_d      = is_jump_in ? fpc_q : (taken ? br_pc : seq_pc);
                state_d     = StPresent;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StFetch;
            fpc_q       <= RESET_PC;
            drop_q      <= 1'b0;
            ins_ready_q <= 1'b0;
            ins_q       <= '0;
            pc_q        <= '0;
            pnpc_q      <= '0;
            nfpc_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_q      <= drop_d;
            ins_ready_q <= ins_ready_d;
            ins_q       <= ins_d;
            pc_q        <= pc_d;
            pnpc_q      <= pnpc_d;
            nfpc_q      <= nfpc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

`ifdef IFETCH_ICACHE_EN
    localparam int unsigned Lines = 1 << ICACHE_IDX_W;
    localparam int unsigned TagW  = 30 - ICACHE_IDX_W;

    logic [Lines-1:0]        valid_q;
    logic [TagW-1:0]         tag_q  [Lines];
    logic [31:0]             data_q [Lines];
    logic [ICACHE_IDX_W-1:0] idx;
    logic [TagW-1:0]         tag;
    logic                    fill;

    assign idx        = fpc_q[ICACHE_IDX_W+1:2];
    assign tag        = fpc_q[31:ICACHE_IDX_W+2];
    assign cache_hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign cache_word = data_q[idx];
    // Only accepted responses are cached; dropped or redirected ones never are.
    assign fill       = rdy_in && !redirect && (state_q == StWait) && bus.mem_ready && !drop_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= bus.mem_data;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = '0;
`endif

    assign bus.ins_ready      = ins_ready_q;
    assign bus.ins            = ins_q;
    assign bus.pc             = pc_q;
    assign bus.predict_nxt_pc = pnpc_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch latency, stall/hold, branch prediction, jump hold,
// redirect priority and drop, address wrap, and a backward loop run twice.
module tb_ifetch_unit;

    localparam int unsigned MemLat = 3;
    localparam logic [31:0] Nop    = 32'h0000_0013;
    localparam logic [31:0] BneM8  = 32'hFE00_1CE3;
    localparam logic [31:0] BneP8  = 32'h0000_1463;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC    (32'h0),
        .ICACHE_IDX_W(4)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .rdy_in  (rdy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [logic [31:0]];
    int unsigned req_cnt;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return Nop;
    endfunction

    // Memory model: request seen in cycle C is answered with a one-cycle pulse in cycle C+3.
    initial begin
        logic [31:0] a;
        req_cnt       = 0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                a = bus.mem_addr;
                req_cnt++;
                repeat (MemLat) @(posedge clk);
                #1;
                bus.mem_data  = rd_mem(a);
                bus.mem_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic consume();
        bus.dec_stall = 1'b0;
        tick(1);
        bus.dec_stall = 1'b1;
    endtask

    task automatic jump(input logic [31:0] a);
        bus.dec_clear    = 1'b1;
        bus.dec_new_addr = a;
        tick(1);
        bus.dec_clear    = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        for (int i = 0; i < 20 && bus.mem_req !== 1'b1; i++) tick(1);
        chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
        chk({tag, "_addr"}, bus.mem_addr, a);
    endtask

    task automatic wait_ins(input string tag);
        for (int i = 0; i < 20 && bus.ins_ready !== 1'b1; i++) tick(1);
        chk({tag, "_rdy"}, {31'd0, bus.ins_ready}, 32'd1);
    endtask

    initial begin
        int unsigned r0;
        logic        seen;
        logic [31:0] loop_pc [3];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rdy   = 1'b1;
        bus.dec_stall    = 1'b1;
        bus.dec_clear    = 1'b0;
        bus.dec_new_addr = '0;
        bus.rob_clear    = 1'b0;
        bus.rob_new_addr = '0;
        imem[32'h0000_0000] = 32'h0010_0093;
        imem[32'h0000_0004] = 32'h0020_0113;
        imem[32'h0000_0008] = BneM8;
        imem[32'h0000_0010] = BneM8;
        imem[32'h0000_0020] = 32'h0000_00EF;
        imem[32'h0000_0050] = BneP8;
        imem[32'h0000_0200] = 32'h0030_0193;
        loop_pc[0] = 32'h0;
        loop_pc[1] = 32'h4;
        loop_pc[2] = 32'h9;

        @(posedge clk);
        #1;
        chk("rst_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("rst_ins", bus.ins, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_pnpc", bus.predict_nxt_pc, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        rst_n = 1'b1;

        // First fetch: request, then ins_ready exactly four cycles later.
        tick(1);
        chk("f0_req", {31'd0, bus.mem_req}, 32'd1);
        chk("f0_addr", bus.mem_addr, 32'h0);
        tick(3);
        chk("f0_early", {31'd0, bus.ins_ready}, 32'd0);
        tick(1);
        chk("f0_rdy", {31'd0, bus.ins_ready}, 32'd1);
        chk("f0_ins", bus.ins, 32'h0010_0093);
        chk("f0_pc", bus.pc, 32'h0);
        chk("f0_pnpc", bus.predict_nxt_pc, 32'h4);
        consume();
        chk("f0_consumed", {31'd0, bus.ins_ready}, 32'd0);
        tick(1);
        chk("f1_req", {31'd0, bus.mem_req}, 32'd1);
        chk("f1_addr", bus.mem_addr, 32'h4);
        tick(4);
        chk("f1_rdy", {31'd0, bus.ins_ready}, 32'd1);
        chk("f1_ins", bus.ins, 32'h0020_0113);
        chk("f1_pc", bus.pc, 32'h4);
        chk("f1_pnpc", bus.predict_nxt_pc, 32'h8);

        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_rdy", {31'd0, bus.ins_ready}, 32'd1);
            chk("stall_ins", bus.ins, 32'h0020_0113);
            chk("stall_pc", bus.pc, 32'h4);
        end

        // Global ready low freezes everything even with the decoder willing to consume.
        rdy = 1'b0;
        bus.dec_stall = 1'b0;
        tick(2);
        chk("rdy_hold_rdy", {31'd0, bus.ins_ready}, 32'd1);
        chk("rdy_hold_pc", bus.pc, 32'h4);
        rdy = 1'b1;
        tick(1);
        bus.dec_stall = 1'b1;
        chk("rdy_consumed", {31'd0, bus.ins_ready}, 32'd0);

        // Backward branch: predicted taken.
        jump(32'h10);
        wait_req("bm8", 32'h10);
        wait_ins("bm8");
        chk("bm8_ins", bus.ins, BneM8);
        chk("bm8_pc", bus.pc, 32'h11);
        chk("bm8_pnpc", bus.predict_nxt_pc, 32'h14);
        consume();
        wait_req("bm8_next", 32'h8);

        // Forward branch: predicted not taken.
        jump(32'h50);
        wait_req("bp8", 32'h50);
        wait_ins("bp8");
        chk("bp8_pc", bus.pc, 32'h50);
        chk("bp8_pnpc", bus.predict_nxt_pc, 32'h58);
        consume();
        wait_req("bp8_next", 32'h54);

        // JAL holds fetch until the decoder redirects.
        jump(32'h20);
        wait_req("jal", 32'h20);
        wait_ins("jal");
        chk("jal_ins", bus.ins, 32'h0000_00EF);
        chk("jal_pc", bus.pc, 32'h20);
        consume();
        r0 = req_cnt;
        tick(6);
        chk("jal_hold_reqs", req_cnt - r0, 32'd0);
        chk("jal_hold_rdy", {31'd0, bus.ins_ready}, 32'd0);
        jump(32'h100);
        chk("jal_redir_noreq", {31'd0, bus.mem_req}, 32'd0);
        tick(1);
        chk("jal_redir_req", {31'd0, bus.mem_req}, 32'd1);
        chk("jal_redir_addr", bus.mem_addr, 32'h100);
        wait_ins("j100");

        // ROB flush while waiting: rob wins over dec, bit 0 cleared, pending word dropped.
        jump(32'h40);
        wait_req("w40", 32'h40);
        bus.rob_clear    = 1'b1;
        bus.rob_new_addr = 32'h201;
        bus.dec_clear    = 1'b1;
        bus.dec_new_addr = 32'h300;
        tick(1);
        bus.rob_clear = 1'b0;
        bus.dec_clear = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && bus.mem_req !== 1'b1; i++) begin
            tick(1);
            if (bus.ins_ready === 1'b1) seen = 1'b1;
        end
        chk("rob_drop_no_ins", {31'd0, seen}, 32'd0);
        chk("rob_req", {31'd0, bus.mem_req}, 32'd1);
        chk("rob_addr", bus.mem_addr, 32'h200);
        wait_ins("rob");
        chk("rob_pc", bus.pc, 32'h200);
        chk("rob_ins", bus.ins, 32'h0030_0193);

        // fpc+4 wraps at the top of the address space.
        jump(32'hFFFF_FFFC);
        wait_req("wrap", 32'hFFFF_FFFC);
        wait_ins("wrap");
        chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_pnpc", bus.predict_nxt_pc, 32'h0);
        consume();
        wait_ins("wrap_next");
        chk("wrap_next_pc", bus.pc, 32'h0);
        chk("wrap_next_ins", bus.ins, 32'h0010_0093);

        // Loop 0x0 -> 0x4 -> 0x8 (branch back to 0x0), twice.
        for (int p = 0; p < 2; p++) begin
            r0 = req_cnt;
            for (int k = 0; k < 3; k++) begin
                chk("loop_pc", bus.pc, loop_pc[k]);
                if (k == 2) chk("loop_br_pnpc", bus.predict_nxt_pc, 32'hC);
                consume();
`ifdef IFETCH_ICACHE_EN
                if (p == 1) begin
                    chk("loop_gap", {31'd0, bus.ins_ready}, 32'd0);
                    tick(1);
                    chk("loop_hit_1cyc", {31'd0, bus.ins_ready}, 32'd1);
                end
`endif
                wait_ins("loop");
            end
`ifdef IFETCH_ICACHE_EN
            chk("loop_reqs", req_cnt - r0, (p == 0) ? 32'd1 : 32'd0);
`else
            chk("loop_reqs", req_cnt - r0, 32'd3);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
